// File: rtl/d_sram_like_bridge_pkg.sv
// Shared definitions for the MEM-stage data SRAM to sram-like bus bridge.
// Bus size codes, bridge state encoding and the wen decode result.
package d_sram_like_bridge_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } bridgeState_e;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] offset;
  } sizeOff_t;

endpackage

// File: rtl/d_sram_like_bridge_if.sv
// Split-transaction sram-like data bus between the bridge and the
// data cache / AXI bridge.
interface d_sram_like_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wdata,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wdata,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );

endinterface

// File: rtl/d_sram_like_bridge_wen_to_size.sv
// Byte-enable decoder: wen[3:0] -> bus size and low address offset.
// Reads and irregular enable patterns fall back to an aligned word.
module d_sram_like_bridge_wen_to_size
  import d_sram_like_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output sizeOff_t   dec
);

  always_comb begin
    dec = '{size: SIZE_WORD, offset: 2'd0};
    unique case (1'b1)
      (wen == 4'b0011): dec = '{size: SIZE_HALF, offset: 2'd0};
      (wen == 4'b1100): dec = '{size: SIZE_HALF, offset: 2'd2};
      (wen == 4'b0001): dec = '{size: SIZE_BYTE, offset: 2'd0};
      (wen == 4'b0010): dec = '{size: SIZE_BYTE, offset: 2'd1};
      (wen == 4'b0100): dec = '{size: SIZE_BYTE, offset: 2'd2};
      (wen == 4'b1000): dec = '{size: SIZE_BYTE, offset: 2'd3};
      default: ;
    endcase
  end

endmodule

// File: rtl/d_sram_like_bridge.sv
// MEM-stage data SRAM strobe to sram-like split-transaction bus bridge.
// Stalls the pipeline until the access completes and the pipeline advances.
module d_sram_like_bridge
  import d_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  input  logic              longest_stall,
  output logic              d_stall,
  d_sram_like_bridge_if.master bus
);

  bridgeState_e state;
  bridgeState_e nextState;

  sizeOff_t          dec;
  logic              wrQ;
  logic [1:0]        sizeQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] rdataQ;
  logic              capture;
  logic              done;
  logic              unusedAddrBits;

  d_sram_like_bridge_wen_to_size uDec (
    .wen (data_sram_wen),
    .dec (dec)
  );

  // Low address bits are replaced by the decoded lane offset.
  assign unusedAddrBits = ^data_sram_addr[1:0];

  assign capture = (state == S_IDLE) && data_sram_en;
  assign done    = bus.data_data_ok &&
                   ((state == S_WAIT) ||
                    ((state == S_REQ) && bus.data_addr_ok));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE: begin
        if (data_sram_en) nextState = S_REQ;
      end
      S_REQ: begin
        if (bus.data_addr_ok) begin
          nextState = bus.data_data_ok ? S_HOLD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.data_data_ok) nextState = S_HOLD;
      end
      S_HOLD: begin
        if (!longest_stall) nextState = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.data_req = 1'b0;
    d_stall      = 1'b0;
    unique case (state)
      S_IDLE: d_stall = data_sram_en;
      S_REQ: begin
        bus.data_req = 1'b1;
        d_stall      = 1'b1;
      end
      S_WAIT: d_stall = 1'b1;
      S_HOLD: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrQ    <= 1'b0;
      sizeQ  <= 2'd0;
      addrQ  <= '0;
      wdataQ <= '0;
    end else if (capture) begin
      wrQ    <= |data_sram_wen;
      sizeQ  <= dec.size;
      addrQ  <= {data_sram_addr[ADDR_W-1:2], dec.offset};
      wdataQ <= data_sram_wdata;
    end
  end

  // Writes latch too; mem_ctrl ignores the value for stores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdataQ <= '0;
    end else if (done) begin
      rdataQ <= bus.data_rdata;
    end
  end

  assign bus.data_wr    = wrQ;
  assign bus.data_size  = sizeQ;
  assign bus.data_addr  = addrQ;
  assign bus.data_wdata = wdataQ;

  assign data_sram_rdata = rdataQ;

endmodule

// File: doc/d_sram_like_bridge.md
Name: d_sram_like_bridge

Overview:
- Downstream neighbour of the datapath's MEM stage.
- Converts the single-cycle data-SRAM strobe (mem_enM, mem_wenM, aluoutM, mem_write_dataM) into the split-transaction sram-like bus (req/addr_ok/data_ok) that feeds the data cache or AXI bridge.
- Returns read data to mem_ctrl.
- Raises d_stall to the hazard unit until the access completes and the rest of the pipeline is ready to advance.

Parameters:
- ADDR_W, 32, width of address bus
- DATA_W, 32, width of data bus; only 32 is supported

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-low reset
- data_sram_en  input  1  MEM-stage access request (mem_enM & load/store)
- data_sram_wen  input  4  byte write enables; 0 = read
- data_sram_addr  input  ADDR_W  byte address (aluoutM)
- data_sram_wdata  input  DATA_W  lane-aligned store data
- data_sram_rdata  output  DATA_W  word returned to mem_ctrl
- longest_stall  input  1  OR of all pipeline stall sources except d_stall
- d_stall  output  1  stall request to hazard unit
- data_req  output  1  bus request
- data_wr  output  1  1 = write
- data_size  output  2  0 = byte, 1 = half, 2 = word
- data_addr  output  ADDR_W  bus address
- data_wdata  output  DATA_W  bus write data
- data_addr_ok  input  1  request accepted this cycle
- data_data_ok  input  1  transaction complete; data_rdata valid
- data_rdata  input  DATA_W  bus read data

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. 2-bit state register with async clear on rst=0.
- Reset values:
  - state=IDLE
  - data_req=0
  - d_stall=0
  - data_sram_rdata=0
  - captured wr/size/addr/wdata registers = 0
- IDLE:
  - if data_sram_en: capture wr, size, addr and wdata into registers; go REQ.
  - d_stall = data_sram_en, combinational in the same cycle.
- REQ:
  - data_req=1; bus outputs are driven from the captured registers.
  - addr_ok & data_ok in the same cycle: latch rdata, go HOLD.
  - addr_ok only: go WAIT.
  - neither: stay in REQ with outputs stable.
- WAIT:
  - data_req=0.
  - on data_ok: latch data_rdata into data_sram_rdata (writes also latch, value unused); go HOLD.
- d_stall=1 throughout REQ and WAIT, including the data_ok cycle.
- HOLD:
  - d_stall=0; data_sram_rdata held.
  - if !longest_stall: go IDLE (pipeline advances this edge).
  - else: stay in HOLD.
  - A new access is never started from HOLD.
- Minimum latency with a zero-wait bus:
  - cycle0 IDLE, en seen
  - cycle1 REQ, addr_ok & data_ok
  - cycle2 HOLD, stall low
  - The pipeline therefore loses 2 cycles per access.
- Size/address rules (combinational, at capture time):
  - wen=0000 (read): size=2, addr={addr[31:2],2'b00}; mem_ctrl extracts the bytes.
  - wen=1111: size=2, offset 0.
  - wen=0011: size=1, offset 0. wen=1100: size=1, offset 2.
  - wen=0001/0010/0100/1000: size=0, offset 0/1/2/3.
  - Any other pattern: size=2, offset 0.
  - addr = {addr[31:2], offset}; wdata is passed unchanged (already lane-aligned).
- Once addr_ok is seen, the transaction always completes; en dropping mid-transaction is illegal while d_stall=1.
- Exceptions: the datapath masks en on AdEL/AdES; the bridge has no flush input.
- Reset mid-transaction: immediate return to IDLE, req deasserted; the bus slave shares rst.
- data_ok arriving in IDLE/REQ-without-addr_ok is a protocol violation and is ignored.

Decomposition:
- Shared package (mycpu_defines): SIZE_BYTE/SIZE_HALF/SIZE_WORD constants and bridge state encodings.
- One natural sub-module, wen_to_size: purely combinational decoder, wen[3:0] -> {size[1:0], offset[1:0]}.
- FSM and capture registers stay in the top module.

Test Plan:
- Read, zero-wait bus: addr=0x8000_1236, wen=0, addr_ok & data_ok in REQ with rdata=0xDEADBEEF.
  - Required: data_addr=0x8000_1234, size=2, wr=0.
  - Required: d_stall high for 2 cycles; data_sram_rdata=0xDEADBEEF in HOLD.
- Byte store: wen=0100, addr=0x1000_0000, wdata=0x00AB0000.
  - Required: data_addr=0x1000_0002, size=0, wr=1, wdata=0x00AB0000.
- Half store: wen=1100. Required: offset 2, size=1.
- Split handshake: addr_ok after 3 REQ cycles, data_ok 4 cycles later.
  - Required: req held with stable address for exactly 3 cycles, then low.
  - Required: d_stall low only on the cycle after data_ok.
- longest_stall held 3 cycles after data_ok.
  - Required: HOLD persists with rdata stable and no new req.
  - Required: IDLE reached on the edge after longest_stall falls; back-to-back access then issues req the following cycle.
- rst=0 asserted asynchronously while in WAIT.
  - Required: req/d_stall/state clear immediately without a clock edge; after release, en=1 starts a fresh REQ.
